feedback_tone_player: RTL

Parametrised lane-aware buzzer feedback engine for the DDR play field. It detects rising edges on per-lane note actions and classifies each as hit or miss from the lane's success bit. Events are queued in a small FIFO and each plays as a fixed-length square-wave tone, with pitch set by result and lane, followed by a silent gap. It sits between the note judge and the board buzzer pin, and adds queuing, per-lane pitch, mute, and drop accounting.

---
 rtl/feedback_tone_player.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/feedback_tone_player.sv
// Buzzer feedback engine: turns per-lane note results into queued square-wave tones
// whose pitch depends on hit/miss and lane, each followed by a silent gap.
module feedback_tone_player #(
    parameter int LANES       = 8,
    parameter int DEPTH       = 4,
    parameter int TONE_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int HIT_HALF    = 25000,
    parameter int MISS_HALF   = 100000,
    parameter int STEP_HALF   = 2500,
    parameter int HALF_W      = 20,
    parameter int DUR_W       = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [LANES-1:0]       i_note_action,
    input  logic [LANES-1:0]       i_note_success,
    input  logic                   i_mute,
    output logic                   o_buzzer,
    output logic                   o_busy,
    output logic [$clog2(LANES):0] o_tone_code,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic                   o_drop_pulse,
    output logic [7:0]             o_drop_count
);
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CODE_W = LANE_W + 1;
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [HALF_W-1:0] HIT_H     = HALF_W'(HIT_HALF);
    localparam logic [HALF_W-1:0] MISS_H    = HALF_W'(MISS_HALF);
    localparam logic [HALF_W-1:0] STEP_H    = HALF_W'(STEP_HALF);
    localparam logic [DUR_W-1:0]  TONE_LAST = DUR_W'(TONE_CYCLES - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam longint HALF_MAX = ((HIT_HALF > MISS_HALF) ? longint'(HIT_HALF) : longint'(MISS_HALF))
                                  + longint'(LANES - 1) * longint'(STEP_HALF);

    if (HALF_MAX >= (longint'(1) << HALF_W)) begin : g_half_w_too_small
        $error("HALF_W cannot hold the largest half-period");
    end
    if (longint'(TONE_CYCLES) > (longint'(1) << DUR_W) || longint'(GAP_CYCLES) > (longint'(1) << DUR_W)) begin : g_dur_w_too_small
        $error("DUR_W cannot hold the tone or gap length");
    end
    if (LANES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geometry
        $error("LANES must be >= 2 and DEPTH a power of two >= 2");
    end

    logic [LANES-1:0]  r_prev;
    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [HALF_W-1:0] r_half, r_half_cnt;
    logic [DUR_W-1:0]  r_dur_cnt, r_gap_cnt;
    logic              r_phase;
    logic [CODE_W-1:0] r_code;
    logic              r_buzzer, r_busy, r_drop_pulse;
    logic [CODE_W-1:0] r_tone_code;
    logic [7:0]        r_drop_count;

    logic [LANES-1:0]  w_rise;
    logic [LANE_W-1:0] w_sel_lane;
    logic              w_event, w_pop, w_push, w_drop;
    logic [CODE_W-1:0] w_head;
    logic [HALF_W-1:0] w_base_half, w_pop_half;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [1:0]        w_state_nxt;
    logic [HALF_W-1:0] w_half_nxt, w_half_cnt_nxt;
    logic [DUR_W-1:0]  w_dur_nxt, w_gap_nxt;
    logic              w_phase_nxt;
    logic [CODE_W-1:0] w_code_nxt;

    assign w_rise      = i_note_action & ~r_prev;
    assign w_event     = |w_rise;
    assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
    assign w_push      = w_event && ((r_count < CNT_W'(DEPTH)) || w_pop);
    assign w_drop      = w_event && !w_push;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_base_half = w_head[LANE_W] ? HIT_H : MISS_H;
    assign w_pop_half  = w_base_half + HALF_W'(w_head[LANE_W-1:0]) * STEP_H;

    // Lowest-index rising lane wins; the others in the same cycle are ignored.
    always_comb begin
        w_sel_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            w_sel_lane = w_rise[i] ? LANE_W'(i) : w_sel_lane;
        end
    end

    // FIFO occupancy after this edge.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Tone sequencer next state: pop in IDLE, square wave in PLAY, silence in GAP.
    always_comb begin
        w_state_nxt    = r_state;
        w_half_nxt     = r_half;
        w_half_cnt_nxt = r_half_cnt;
        w_dur_nxt      = r_dur_cnt;
        w_gap_nxt      = r_gap_cnt;
        w_phase_nxt    = r_phase;
        w_code_nxt     = r_code;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt    = ST_PLAY;
                    w_code_nxt     = w_head;
                    w_half_nxt     = w_pop_half;
                    w_half_cnt_nxt = w_pop_half - HALF_W'(1);
                    w_dur_nxt      = TONE_LAST;
                    w_phase_nxt    = 1'b1;
                end else begin
                    w_phase_nxt    = 1'b0;
                end
            end
            ST_PLAY: begin
                if (r_dur_cnt == '0) begin
                    w_phase_nxt = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GAP_LAST;
                    end
                end else begin
                    w_dur_nxt = r_dur_cnt - DUR_W'(1);
                    if (r_half_cnt == '0) begin
                        w_phase_nxt    = ~r_phase;
                        w_half_cnt_nxt = r_half - HALF_W'(1);
                    end else begin
                        w_half_cnt_nxt = r_half_cnt - HALF_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - DUR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // Event storage; contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_note_success[w_sel_lane], w_sel_lane};
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev       <= i_note_action;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= ST_IDLE;
            r_half       <= HALF_W'(1);
            r_half_cnt   <= '0;
            r_dur_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_phase      <= 1'b0;
            r_code       <= '0;
            r_buzzer     <= 1'b0;
            r_busy       <= 1'b0;
            r_tone_code  <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_prev       <= i_note_action;
            r_wr_ptr     <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_rd_ptr     <= w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_count      <= w_count_nxt;
            r_state      <= w_state_nxt;
            r_half       <= w_half_nxt;
            r_half_cnt   <= w_half_cnt_nxt;
            r_dur_cnt    <= w_dur_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_phase      <= w_phase_nxt;
            r_code       <= w_code_nxt;
            r_buzzer     <= w_phase_nxt & ~i_mute & (w_state_nxt == ST_PLAY);
            r_busy       <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
            r_tone_code  <= (w_state_nxt == ST_PLAY) ? w_code_nxt : '0;
            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_count != 8'd255) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign o_buzzer     = r_buzzer;
    assign o_busy       = r_busy;
    assign o_tone_code  = r_tone_code;
    assign o_fifo_level = r_count;
    assign o_drop_pulse = r_drop_pulse;
    assign o_drop_count = r_drop_count;
endmodule
